// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 16:1 mux:
// FSM state encoding, requester/select widths, default hold limit and a
// one-hot decode helper.
package mux_arb_pkg;

    localparam int N_REQ        = 16;
    localparam int SEL_W        = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Decode an owner index into a one-hot grant vector (bit 0 is the MSB).
    function automatic logic [0:N_REQ-1] onehot(input logic [0:SEL_W-1] idx);
        logic [0:N_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesting units (master side) and the
// arbiter (slave side).
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [0:N_REQ-1] req;
    logic             done;
    logic [0:N_REQ-1] gnt;
    logic             gnt_valid;
    logic [0:SEL_W-1] sel;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  sel,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output sel,
        output timeout
    );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating-priority encoder: finds the first set request at or after ptr,
// wrapping modulo 16. Purely combinational.
module rr_pick16
    import mux_arb_pkg::*;
(
    input  logic [0:N_REQ-1] req,
    input  logic [0:SEL_W-1] ptr,
    output logic             found,
    output logic [0:SEL_W-1] idx
);

    logic [0:N_REQ-1] rot_s;
    logic [0:SEL_W-1] first_s;

    // Rotate the request vector so that position 0 corresponds to ptr.
    always_comb begin
        rot_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rot_s[j] = req[SEL_W'(ptr + SEL_W'(j))];
        end
    end

    // Fixed-priority find-first on the rotated vector; lowest position wins.
    always_comb begin
        first_s = '0;
        found   = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                first_s = SEL_W'(j);
                found   = 1'b1;
            end else begin
                first_s = first_s;
            end
        end
    end

    // Undo the rotation to get the absolute requester index.
    assign idx = first_s + ptr;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 16:1 mux among 16 requesters. An owner
// keeps the mux until done, until it drops its request, or until the hold
// limit expires; a one-cycle GAP separates successive owners so the mux
// output never switches directly between two owners.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);

    arb_state_e       state_r,     state_s;
    logic [0:N_REQ-1] gnt_r,       gnt_s;
    logic             gnt_valid_r, gnt_valid_s;
    logic [0:SEL_W-1] sel_r,       sel_s;
    logic             timeout_r,   timeout_s;
    logic [0:SEL_W-1] ptr_r,       ptr_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;

    logic             found_s;
    logic [0:SEL_W-1] idx_s;
    logic             hold_hit_s;
    logic             release_s;

    rr_pick16 u_pick (
        .req   (bus.req),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (idx_s)
    );

    // Release conditions for the current owner (sel_r holds the owner index).
    always_comb begin
        hold_hit_s = (MAX_HOLD != 32'sd0) && (cnt_r == CNT_W'(MAX_HOLD - 1));
        release_s  = bus.done || !bus.req[sel_r] || hold_hit_s;
    end

    // Next-state and next-output logic for the IDLE/OWN/GAP sequencer.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_valid_s = gnt_valid_r;
        sel_s       = sel_r;
        timeout_s   = 1'b0;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s     = OWN;
                    gnt_s       = onehot(idx_s);
                    gnt_valid_s = 1'b1;
                    sel_s       = idx_s;
                    cnt_s       = '0;
                end else begin
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                end
            end
            OWN: begin
                if (release_s) begin
                    state_s     = GAP;
                    gnt_s       = '0;
                    gnt_valid_s = 1'b0;
                    ptr_s       = sel_r + 4'd1;
                    // Pulse only when the hold limit was the sole cause.
                    timeout_s   = hold_hit_s && !bus.done && bus.req[sel_r];
                end else begin
                    cnt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                state_s     = IDLE;
                gnt_s       = '0;
                gnt_valid_s = 1'b0;
            end
            default: begin
                state_s     = IDLE;
                gnt_s       = '0;
                gnt_valid_s = 1'b0;
                cnt_s       = '0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs; reset acts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            sel_r       <= '0;
            timeout_r   <= 1'b0;
            ptr_r       <= '0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_valid_r <= gnt_valid_s;
            sel_r       <= sel_s;
            timeout_r   <= timeout_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.sel       = sel_r;
    assign bus.timeout   = timeout_r;

endmodule
